// File: rtl/fifo_rd_stream_if.sv
// Read-side FIFO port plus downstream valid/ready byte stream for fifo_rd_stream.
// master = the stream block itself, slave = the FIFO / downstream side.
interface fifo_rd_stream_if #(
  parameter int unsigned DW = 8
);
  logic          fifo_empty;
  logic          fifo_pop;
  logic [DW-1:0] fifo_out;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    input  fifo_empty, fifo_out, m_ready,
    output fifo_pop, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_out, m_ready,
    input  fifo_pop, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read consumer: pops bytes, absorbs 1-cycle read latency in a 2-entry skid buffer,
// streams them out framed into PKT_LEN-byte packets. FIFO_RD_STREAM_STATS_EN adds packet/stall counters.
module fifo_rd_stream #(
  parameter int unsigned DW      = 8,
  parameter int unsigned PKT_LEN = 16,
  parameter int unsigned CW      = $clog2(PKT_LEN)
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              enable,
  fifo_rd_stream_if.master  bus,
  output logic              busy
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  input  logic              clr_stats,
  output logic [15:0]       pkt_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int unsigned OW = 2;

  logic [OW-1:0] occ;
  logic          inflight;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          accept;
  logic [2:0]    pending;

  assign bus.m_valid = (occ != OW'(0));
  assign bus.m_data  = head;
  assign bus.m_last  = bus.m_valid && (cnt == CW'(PKT_LEN - 1));
  assign accept      = bus.m_valid && bus.m_ready;
  assign busy        = inflight || (occ != OW'(0));

  // Slots already committed after this cycle's accept; never underflows since accept implies occ>=1.
  assign pending      = 3'(occ) + 3'(inflight) - 3'(accept);
  assign bus.fifo_pop = rrst_n && enable && !bus.fifo_empty && (pending < 3'd2);

  // Skid buffer: head is presented downstream, tail holds the second byte.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= bus.fifo_pop;
      unique case ({inflight, accept})
        2'b10: begin
          if (occ == OW'(0)) head <= bus.fifo_out;
          else               tail <= bus.fifo_out;
          occ <= occ + OW'(1);
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - OW'(1);
        end
        2'b11: begin
          if (occ == OW'(2)) begin
            head <= tail;
            tail <= bus.fifo_out;
          end else begin
            head <= bus.fifo_out;
          end
        end
        default: ;
      endcase
    end
  end

  // In-packet byte counter; wraps after the last byte of each packet.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= bus.m_last ? '0 : cnt + CW'(1);
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  // Packet counter wraps; stall counter saturates; clear beats a same-cycle increment.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else if (clr_stats) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (accept && bus.m_last) pkt_count <= pkt_count + 16'd1;
      if (bus.m_valid && !bus.m_ready && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO on the read side.
// Stats checks compile in only with FIFO_RD_STREAM_STATS_EN.
module tb_fifo_rd_stream;

  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  logic enable = 1'b0;
  logic busy;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic        clr_stats = 1'b0;
  logic [15:0] pkt_count;
  logic [15:0] stall_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_rd_stream_if #(.DW(8)) bus ();

  fifo_rd_stream #(.DW(8), .PKT_LEN(16)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .enable (enable),
    .bus    (bus),
    .busy   (busy)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .clr_stats   (clr_stats),
    .pkt_count   (pkt_count),
    .stall_count (stall_count)
`endif
  );

  always #5 rclk = ~rclk;

  // Read-side FIFO model: data appears one cycle after the pop; reset empties it.
  logic [7:0] mem [0:255];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;

  assign bus.fifo_empty = (rp == wp);

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rp           <= wp;
      bus.fifo_out <= 8'h00;
    end else if (bus.fifo_pop) begin
      bus.fifo_out <= mem[rp];
      rp           <= rp + 8'd1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp      = wp + 8'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Samples accepted bytes until n have been seen; first = samples before the first accept.
  task automatic collect(input string tag, input logic [7:0] base, input int n, input int cnt0,
                         output int first, output int span);
    int got;
    int t;
    got   = 0;
    t     = 0;
    first = -1;
    span  = 0;
    while (got < n && t < 400) begin
      if (bus.m_valid && bus.m_ready) begin
        chk({tag, "_data"}, 32'(bus.m_data), 32'(base + 8'(got)));
        chk({tag, "_last"}, 32'(bus.m_last), 32'(((cnt0 + got) % 16) == 15));
        if (first < 0) first = t;
        span = t - first;
        got++;
      end
      @(negedge rclk);
      t++;
    end
    if (got != n) chk({tag, "_timeout"}, 32'(got), 32'(n));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pop"},   32'(bus.fifo_pop), 32'd0);
    chk({tag, "_valid"}, 32'(bus.m_valid),  32'd0);
    chk({tag, "_busy"},  32'(busy),         32'd0);
  endtask

  int first;
  int span;
  int pops;
  int waits;

  initial begin
    bus.m_ready = 1'b0;

    // Reset values
    @(negedge rclk);
    chk_idle("rst");
    chk("rst_data", 32'(bus.m_data), 32'd0);
    chk("rst_last", 32'(bus.m_last), 32'd0);
    @(negedge rclk);
    rrst_n = 1'b1;
    @(negedge rclk);

    // Streaming: 32 bytes, no bubbles, last on 0x0F and 0x1F
    for (int i = 0; i < 32; i++) push(8'(i));
    bus.m_ready = 1'b1;
    enable      = 1'b1;
    #1;
    chk("st_pop", 32'(bus.fifo_pop), 32'd1);
    @(negedge rclk);
    chk("st_valid_n1", 32'(bus.m_valid), 32'd0);
    chk("st_busy_n1",  32'(busy),        32'd1);
    collect("st", 8'h00, 32, 0, first, span);
    chk("st_latency", 32'(first), 32'd1);
    chk("st_span",    32'(span),  32'd31);
    chk_idle("st_end");

    // Back-pressure: exactly two pops, head held
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    #1;
    pops = int'(bus.fifo_pop);
    for (int i = 0; i < 7; i++) begin
      @(negedge rclk);
      pops += int'(bus.fifo_pop);
      if (bus.m_valid) chk("bp_hold", 32'(bus.m_data), 32'h00);
    end
    chk("bp_pops",  32'(pops),         32'd2);
    chk("bp_valid", 32'(bus.m_valid),  32'd1);
    chk("bp_last",  32'(bus.m_last),   32'd0);
    chk("bp_busy",  32'(busy),         32'd1);
    bus.m_ready = 1'b1;
    collect("bp", 8'h00, 8, 0, first, span);
    chk_idle("bp_end");

    // Empty edge: single byte 0xA5
    push(8'hA5);
    #1;
    chk("em_pop", 32'(bus.fifo_pop), 32'd1);
    @(negedge rclk);
    chk("em_pop_n1",   32'(bus.fifo_pop),   32'd0);
    chk("em_empty_n1", 32'(bus.fifo_empty), 32'd1);
    chk("em_valid_n1", 32'(bus.m_valid),    32'd0);
    chk("em_busy_n1",  32'(busy),           32'd1);
    @(negedge rclk);
    chk("em_valid_n2", 32'(bus.m_valid), 32'd1);
    chk("em_data_n2",  32'(bus.m_data),  32'hA5);
    chk("em_last_n2",  32'(bus.m_last),  32'd0);
    @(negedge rclk);
    chk_idle("em_end");

    // Mid-stream reset with a full buffer
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    repeat (4) @(negedge rclk);
    chk("mr_valid", 32'(bus.m_valid), 32'd1);
    chk("mr_data",  32'(bus.m_data),  32'h40);
    chk("mr_pop",   32'(bus.fifo_pop), 32'd0);
    rrst_n = 1'b0;
    #1;
    chk_idle("mr_async");
    chk("mr_async_data", 32'(bus.m_data), 32'd0);
    chk("mr_async_last", 32'(bus.m_last), 32'd0);
    @(negedge rclk);
    @(negedge rclk);
    rrst_n      = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      chk_idle("mr_post");
    end

    // enable toggle: in-flight byte delivered, then resume; last on 16th byte overall
    for (int i = 0; i < 20; i++) push(8'h80 + 8'(i));
    #1;
    chk("en_pop", 32'(bus.fifo_pop), 32'd1);
    @(negedge rclk);
    enable = 1'b0;
    #1;
    chk("en_pop_off", 32'(bus.fifo_pop), 32'd0);
    collect("en1", 8'h80, 1, 0, first, span);
    chk_idle("en_paused");
    @(negedge rclk);
    chk("en_pop_off2", 32'(bus.fifo_pop), 32'd0);
    enable = 1'b1;
    collect("en2", 8'h81, 19, 1, first, span);

`ifdef FIFO_RD_STREAM_STATS_EN
    // Stats: clear, then two packets with five stall cycles (counter at 4 in-packet)
    clr_stats = 1'b1;
    @(negedge rclk);
    clr_stats = 1'b0;
    chk("sx_pkt0",   32'(pkt_count),   32'd0);
    chk("sx_stall0", 32'(stall_count), 32'd0);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 28; i++) push(8'h20 + 8'(i));
    waits = 0;
    while (!bus.m_valid && waits < 20) begin
      @(negedge rclk);
      waits++;
    end
    chk("sx_valid", 32'(bus.m_valid), 32'd1);
    repeat (5) @(negedge rclk);
    bus.m_ready = 1'b1;
    collect("sx", 8'h20, 28, 4, first, span);
    chk("sx_pkt",   32'(pkt_count),   32'd2);
    chk("sx_stall", 32'(stall_count), 32'd5);
    clr_stats = 1'b1;
    @(negedge rclk);
    clr_stats = 1'b0;
    chk("sx_pkt_clr",   32'(pkt_count),   32'd0);
    chk("sx_stall_clr", 32'(stall_count), 32'd0);
`endif

    @(negedge rclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
